uart_frame_tx: RTL and testbench

Packetizer sitting directly upstream of the UART byte transmitter in the DDS control/report path. Accepts one 8-bit command plus one 32-bit data word per handshake. Emits an 8-byte frame (2 header bytes, command, 4 data bytes MSB first, checksum) one byte at a time through the transmitter's single-cycle enable / done interface. A watchdog aborts the frame if the transmitter stops acknowledging.

---
 rtl/uart_frame_tx.sv | 143 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// Frame packetizer ahead of the UART byte transmitter: sends HEADER0, HEADER1, cmd,
// data[31:0] MSB first and an 8-bit additive checksum, one byte per enable/done handshake.
module uart_frame_tx #(
    parameter logic [7:0]  HEADER0        = 8'hAA,
    parameter logic [7:0]  HEADER1        = 8'h55,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [7:0]  frame_cmd,
    input  logic [31:0] frame_data,
    output logic        frame_ready,
    output logic        frame_done,
    output logic        frame_err,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_done
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES != 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic [15:0] TO_LAST  = (TIMEOUT_CYCLES != 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [7:0]  cmd_q;
    logic [31:0] data_q;
    logic [7:0]  chk_q;
    logic [15:0] wdog_q;
    logic [15:0] gap_q;
    logic        ready_q;
    logic        done_q;
    logic        err_q;
    logic        en_q;
    logic [7:0]  txd_q;
    logic [2:0]  idx_d;

    function automatic logic [7:0] checksum(input logic [7:0] c, input logic [31:0] d);
        return c + d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] c,
                                              input logic [31:0] d, input logic [7:0] chk);
        case (idx)
            3'd0:    return HEADER0;
            3'd1:    return HEADER1;
            3'd2:    return c;
            3'd3:    return d[31:24];
            3'd4:    return d[23:16];
            3'd5:    return d[15:8];
            3'd6:    return d[7:0];
            default: return chk;
        endcase
    endfunction

    assign idx_d = idx_q + 3'd1;

    // The enable and its byte are registered on the edge that enters SEND, so the SEND
    // cycle is exactly the single cycle uart_tx_en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cmd_q   <= 8'h00;
            data_q  <= 32'h0;
            chk_q   <= 8'h00;
            wdog_q  <= 16'd0;
            gap_q   <= 16'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            txd_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            en_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_valid) begin
                        cmd_q   <= frame_cmd;
                        data_q  <= frame_data;
                        chk_q   <= checksum(frame_cmd, frame_data);
                        idx_q   <= 3'd0;
                        ready_q <= 1'b0;
                        en_q    <= 1'b1;
                        txd_q   <= HEADER0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    wdog_q  <= 16'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (uart_tx_done) begin
                        if (idx_q == 3'd7) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_d;
                            if (GAP_CYCLES != 0) begin
                                gap_q   <= 16'd0;
                                state_q <= GAP;
                            end else begin
                                en_q    <= 1'b1;
                                txd_q   <= frame_byte(idx_d, cmd_q, data_q, chk_q);
                                state_q <= SEND;
                            end
                        end
                    end else if (wdog_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        en_q    <= 1'b1;
                        txd_q   <= frame_byte(idx_q, cmd_q, data_q, chk_q);
                        state_q <= SEND;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_ready  = ready_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign uart_tx_en   = en_q;
    assign uart_tx_data = txd_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: instance 0 has no gap, instance 1 has a 5-clock gap; both
// share a 100-clock watchdog and a transmitter model answering 20 clocks after enable.
module tb_uart_frame_tx;

    localparam int DELAY = 20;
    localparam int TO    = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        fv, frame_ready, frame_done, frame_err, tx_en, tx_done, mdone, spur;
    logic [1:0][7:0]   fcmd, tx_data;
    logic [1:0][31:0]  fdata;

    assign tx_done = mdone | spur;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        uart_frame_tx #(
            .HEADER0(8'hAA), .HEADER1(8'h55),
            .GAP_CYCLES(gi == 0 ? 0 : 5), .TIMEOUT_CYCLES(TO)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .frame_valid(fv[gi]), .frame_cmd(fcmd[gi]), .frame_data(fdata[gi]),
            .frame_ready(frame_ready[gi]), .frame_done(frame_done[gi]), .frame_err(frame_err[gi]),
            .uart_tx_en(tx_en[gi]), .uart_tx_data(tx_data[gi]), .uart_tx_done(tx_done[gi])
        );
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: answers the first resp_lim enables of each frame
    int resp_lim = 8;
    int cnt [2];
    int en_cnt [2];
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                cnt[g]    <= 0;
                en_cnt[g] <= 0;
                mdone[g]  <= 1'b0;
            end else begin
                mdone[g] <= 1'b0;
                if (tx_en[g]) begin
                    if (en_cnt[g] < resp_lim) cnt[g] <= DELAY;
                    en_cnt[g] <= en_cnt[g] + 1;
                end else begin
                    if (frame_ready[g]) en_cnt[g] <= 0;
                    if (cnt[g] == 1) begin
                        mdone[g] <= 1'b1;
                        cnt[g]   <= 0;
                    end else if (cnt[g] > 1) begin
                        cnt[g] <= cnt[g] - 1;
                    end
                end
            end
        end
    end

    typedef struct {
        int unsigned inst;
        int unsigned cyc;
        int unsigned kind;   // 0 enable, 1 tx_done, 2 frame_done, 3 frame_err
        logic [7:0]  b;
        logic        rdy;
    } ev_t;
    ev_t ev_q[$];
    ev_t mon_e;
    logic [1:0]      prev_en;
    logic [1:0][7:0] prev_d;
    int mon_viol = 0;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mon_e.inst = g;
            mon_e.cyc  = cyc;
            mon_e.b    = tx_data[g];
            mon_e.rdy  = frame_ready[g];
            if (tx_en[g])       begin mon_e.kind = 0; ev_q.push_back(mon_e); end
            if (tx_done[g])     begin mon_e.kind = 1; ev_q.push_back(mon_e); end
            if (frame_done[g])  begin mon_e.kind = 2; ev_q.push_back(mon_e); end
            if (frame_err[g])   begin mon_e.kind = 3; ev_q.push_back(mon_e); end
            if (rst_n) begin
                if (tx_en[g] && prev_en[g]) mon_viol <= mon_viol + 1;
                if (!tx_en[g] && tx_data[g] !== prev_d[g]) mon_viol <= mon_viol + 1;
            end
            prev_en[g] <= tx_en[g];
            prev_d[g]  <= tx_data[g];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected frame from the byte-order and checksum rules
    function automatic logic [63:0] ref_frame(input logic [7:0] c, input logic [31:0] d);
        int s;
        s = int'(c) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
        s = s % 256;
        return {8'hAA, 8'h55, c, d, 8'(s)};
    endfunction

    int unsigned ecyc[$], dcyc[$], fdcyc[$], fecyc[$];
    logic [7:0]  eb[$];
    logic        erdy[$], ferdy[$];

    task automatic gather(input int g, input int base);
        ecyc.delete(); dcyc.delete(); fdcyc.delete(); fecyc.delete();
        eb.delete(); erdy.delete(); ferdy.delete();
        for (int i = base; i < ev_q.size(); i++) begin
            if (ev_q[i].inst == g) begin
                case (ev_q[i].kind)
                    0: begin ecyc.push_back(ev_q[i].cyc); eb.push_back(ev_q[i].b); erdy.push_back(ev_q[i].rdy); end
                    1: dcyc.push_back(ev_q[i].cyc);
                    2: fdcyc.push_back(ev_q[i].cyc);
                    default: begin fecyc.push_back(ev_q[i].cyc); ferdy.push_back(ev_q[i].rdy); end
                endcase
            end
        end
    endtask

    function automatic logic [63:0] bytes64(input int from);
        logic [63:0] v = 64'h0;
        for (int i = 0; i < 8; i++)
            v = {v[55:0], (from + i < eb.size()) ? eb[from + i] : 8'h00};
        return v;
    endfunction

    function automatic logic [63:0] counts();
        return 64'(ecyc.size() * 100 + fdcyc.size() * 10 + fecyc.size());
    endfunction

    task automatic wait_ready(input int g, input logic val, input int limit, input string name);
        int k = 0;
        while (frame_ready[g] !== val && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (frame_ready[g] !== val) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: frame_ready stuck at %0b, wanted %0b", name, frame_ready[g], val);
        end
    endtask

    task automatic send_frame(input int g, input logic [7:0] c, input logic [31:0] d);
        wait_ready(g, 1'b1, 2000, "ready_before_send");
        fv[g] = 1'b1;
        fcmd[g] = c;
        fdata[g] = d;
        @(negedge clk);
        fv[g] = 1'b0;
    endtask

    task automatic run_frame(input int g, input logic [7:0] c, input logic [31:0] d);
        int base;
        base = ev_q.size();
        send_frame(g, c, d);
        wait_ready(g, 1'b1, 2000, "frame_end");
        @(negedge clk);
        gather(g, base);
    endtask

    task automatic check_reset(input int g, input string name);
        check(name, 64'({frame_ready[g], frame_done[g], frame_err[g], tx_en[g], tx_data[g]}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [7:0]  chk;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got none, expected summary");
        $fatal(1);
    end

    initial begin
        logic [7:0]  c, c2;
        logic [31:0] d, d2;
        int base, k;

        vecs[0] = '{8'h01, 32'h12345678, 8'h15};
        vecs[1] = '{8'hFF, 32'hFFFFFFFF, 8'hFB};
        vecs[2] = '{8'h00, 32'h00000000, 8'h00};
        vecs[3] = '{8'h10, 32'h01020304, 8'h1A};
        vecs[4] = '{8'h80, 32'h80808080, 8'h80};
        vecs[5] = '{8'hAA, 32'h55AA55AA, 8'hA8};

        rst_n = 1'b0; fv = '0; fcmd = '0; fdata = '0; spur = '0;
        repeat (3) @(negedge clk);
        check_reset(0, "reset_state0");
        check_reset(1, "reset_state1");
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(0, vecs[i].cmd, vecs[i].data);
            check($sformatf("vec%0d_bytes", i), bytes64(0),
                  {8'hAA, 8'h55, vecs[i].cmd, vecs[i].data, vecs[i].chk});
            check($sformatf("vec%0d_counts", i), counts(), 64'd810);
            if (i == 0) begin
                for (int j = 1; j < 8; j++)
                    check($sformatf("nogap_spacing%0d", j), 64'(ecyc[j] - dcyc[j-1]), 64'd1);
                check("done_after_last", 64'(fdcyc[0] - dcyc[7]), 64'd1);
            end
        end

        repeat (12) begin
            c = 8'($urandom);
            d = $urandom;
            run_frame(0, c, d);
            check("rand_frame", bytes64(0), ref_frame(c, d));
            check("rand_counts", counts(), 64'd810);
        end

        // Back-to-back frames with frame_valid held high
        c = 8'($urandom); d = $urandom; c2 = 8'($urandom); d2 = $urandom;
        base = ev_q.size();
        fv[0] = 1'b1; fcmd[0] = c; fdata[0] = d;
        wait_ready(0, 1'b0, 10, "b2b_accept1");
        fcmd[0] = c2; fdata[0] = d2;
        wait_ready(0, 1'b1, 2000, "b2b_end1");
        @(negedge clk);
        fv[0] = 1'b0;
        wait_ready(0, 1'b1, 2000, "b2b_end2");
        @(negedge clk);
        gather(0, base);
        check("b2b_frame1", bytes64(0), ref_frame(c, d));
        check("b2b_frame2", bytes64(8), ref_frame(c2, d2));
        check("b2b_counts", counts(), 64'd1620);
        check("b2b_next_enable", 64'(ecyc[8] - dcyc[7]), 64'd2);
        check("b2b_frame_done", 64'(fdcyc[0] - dcyc[7]), 64'd1);
        k = 0;
        foreach (erdy[i]) if (erdy[i]) k++;
        check("b2b_ready_low", 64'(k), 64'd0);

        // Inter-byte gap on instance 1
        c = 8'($urandom); d = $urandom;
        run_frame(1, c, d);
        check("gap_frame", bytes64(0), ref_frame(c, d));
        check("gap_counts", counts(), 64'd810);
        for (int j = 1; j < 8; j++)
            check($sformatf("gap_spacing%0d", j), 64'(ecyc[j] - dcyc[j-1]), 64'd6);

        // Transmitter goes silent after the third byte
        resp_lim = 3;
        c = 8'($urandom); d = $urandom;
        run_frame(0, c, d);
        resp_lim = 8;
        check("to_partial_bytes", bytes64(0), {8'hAA, 8'h55, c, d[31:24], 32'h0});
        check("to_counts", counts(), 64'd401);
        check("to_err_latency", 64'(fecyc[0] - ecyc[3]), 64'd101);
        check("to_ready_with_err", 64'(ferdy[0]), 64'd1);
        c = 8'($urandom); d = $urandom;
        run_frame(0, c, d);
        check("to_next_frame", bytes64(0), ref_frame(c, d));

        // Asynchronous reset in the middle of byte 5
        c = 8'($urandom); d = $urandom;
        base = ev_q.size();
        send_frame(0, c, d);
        k = 0;
        gather(0, base);
        while (ecyc.size() < 6 && k < 1000) begin
            @(negedge clk);
            gather(0, base);
            k++;
        end
        check("rst_reached_byte5", 64'(ecyc.size()), 64'd6);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset(0, "async_reset0");
        check_reset(1, "async_reset1");
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); spur = 2'b11;
            @(negedge clk); spur = 2'b00;
            repeat (3) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        gather(0, base);
        check("rst_no_pulses_no_enables", counts(), 64'd600);
        gather(1, base);
        check("spurious_inst1", counts(), 64'd0);
        check_reset(0, "idle_after_spurious");
        c = 8'($urandom); d = $urandom;
        run_frame(0, c, d);
        check("post_reset_frame", bytes64(0), ref_frame(c, d));
        check("post_reset_counts", counts(), 64'd810);

        check("monitor_protocol", 64'(mon_viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
